// File: rtl/tdm_demux_1_4.sv
// Receive-side 1:4 TDM demultiplexer: tracks the slot position from frame_sync,
// collects one frame into shadow registers and updates y0..y3 together once per frame.
//
// state | meaning
// HUNT  | unsynchronised; waiting for an en sample with frame_sync=1
// RUN   | locked; slot counter gives the index of the next sample
module tdm_demux_1_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             s1,
  output logic             s0,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q, y0_d, y1_d, y2_d, y3_d;
  logic             fv_q, fv_d, se_q, se_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (frame_sync) begin
            // a sync mid-frame restarts the frame; the partial frame is dropped
            se_d   = (slot_q != 2'd0);
            sh0_d  = din;
            slot_d = 2'd1;
          end else begin
            case (slot_q)
              2'd0: begin
                se_d    = 1'b1;
                state_d = HUNT;
              end
              2'd1: begin
                sh1_d  = din;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = din;
                slot_d = 2'd3;
              end
              default: begin
                y0_d   = sh0_q;
                y1_d   = sh1_q;
                y2_d   = sh2_q;
                y3_d   = din;
                fv_d   = 1'b1;
                slot_d = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign s1          = slot_q[1];
  assign s0          = slot_q[0];
  assign frame_valid = fv_q;
  assign sync_err    = se_q;

endmodule

// File: doc/tdm_demux_1_4.md
Name: tdm_demux_1_4

Overview:
- Receive-side counterpart of the 4:1 mux: takes a time-division-multiplexed stream (slot 0..3, repeating) and rebuilds four parallel channels.
- Tracks slot position with a frame-sync marker and a 2-bit slot counter that reproduces the transmitter's select (s1,s0).
- Updates the four outputs atomically once per complete frame, with a valid pulse.
- Flags framing errors and recovers from them.

Parameters:
- WIDTH, 1, bits per slot. The width of din and of each of y0..y3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- din  input  WIDTH  serial slot data.
- en  input  1  sample strobe. din and frame_sync are meaningful only when en=1.
- frame_sync  input  1  high with en on the slot-0 sample of each frame.
- y0  output  WIDTH  channel 0, registered.
- y1  output  WIDTH  channel 1, registered.
- y2  output  WIDTH  channel 2, registered.
- y3  output  WIDTH  channel 3, registered.
- s1  output  1  MSB of the next slot to be captured.
- s0  output  1  LSB of the next slot to be captured.
- frame_valid  output  1  one-cycle pulse; y0..y3 were just updated.
- sync_err  output  1  one-cycle pulse; a framing error was detected.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - y0..y3=0, frame_valid=0, sync_err=0, {s1,s0}=0.
  - Shadow regs sh0..sh2 cleared; state=HUNT.
  - Reset has priority over all other inputs, including mid-frame. A partial frame is discarded and y keeps 0.
- State HUNT (unsynchronised):
  - en=1 & frame_sync=1: sh0<=din, slot<=1, state<=RUN.
  - Any other en=1 sample is discarded silently. No sync_err is raised in HUNT.
- State RUN, on each edge with en=1:
  - frame_sync=1 & slot==0: normal frame start. sh0<=din, slot<=1.
  - frame_sync=1 & slot!=0: early sync.
    - sync_err<=1; partial frame discarded.
    - sh0<=din, slot<=1; state stays RUN.
    - y0..y3 unchanged.
  - frame_sync=0 & slot==0: missing sync.
    - sync_err<=1, state<=HUNT, sample discarded.
    - y0..y3 unchanged.
  - frame_sync=0 & slot in 1..2: sh[slot]<=din, slot<=slot+1.
  - frame_sync=0 & slot==3: frame complete.
    - Same edge: y0<=sh0, y1<=sh1, y2<=sh2, y3<=din, frame_valid<=1.
    - slot wraps to 0; state stays RUN.
- en=0:
  - No state, slot, shadow or y change.
  - frame_sync and din are ignored.
- Pulses:
  - frame_valid and sync_err are high exactly one cycle after the triggering edge, then return to 0 on the next edge.
  - They are never high together.
- Slot counter:
  - {s1,s0} always equals the slot, meaning the next sample index.
  - It is 0 in HUNT.
- Latency:
  - A captured frame appears on y0..y3 in the cycle after the slot-3 sample edge.
  - frame_valid is high in that same cycle.
  - With back-to-back en, the minimum frame period is 4 cycles.
- y0..y3 hold their last completed frame indefinitely. Errors never corrupt them.

Test Plan:
- Reset then back-to-back frame, WIDTH=1: en=1; din 1,0,1,0 with frame_sync on the first sample -> after 4th edge: y0=1, y1=0, y2=1, y3=0, frame_valid=1 for 1 cycle; {s1,s0} sequence 0,1,2,3,0.
- Gapped strobe: same frame with en=0 for 2 cycles between each sample -> identical y; frame_valid only after the 4th en sample; y/slot stable during gaps.
- Early sync: frame_sync at slot 2 with din=1, then 0,1,1 -> sync_err pulse at slot 2; previous y held; next frame_valid gives y=1,0,1,1.
- Missing sync: after a good frame, next en sample has frame_sync=0 -> sync_err pulse, {s1,s0}=0, state HUNT; samples ignored until frame_sync; a following good frame 0,1,1,0 gives y=0,1,1,0.
- Reset mid-frame: rst_n=0 after 2 samples -> all outputs 0 next cycle; no frame_valid; a subsequent frame decodes correctly.
- Sync in HUNT without en: frame_sync=1, en=0 from reset -> stays HUNT, {s1,s0}=0, no pulses.
